// File: rtl/noc_flit_credit_rx.sv
// Receive end of a credit-based NoC flit link: buffers incoming flits in a
// first-word-fall-through FIFO, presents them as AXI-Stream and returns one credit per pop.
module noc_flit_credit_rx #(
  parameter int TID_WIDTH         = 2,
  parameter int TDEST_WIDTH       = 4,
  parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
  parameter int FLIT_WIDTH        = 64,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int OCC_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [FLIT_WIDTH-1:0]  axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  output logic [OCC_WIDTH-1:0]   occupancy,
  output logic                   overflow_err
);

  localparam int PTR_WIDTH = $clog2(FLIT_BUFFER_DEPTH);
  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [OCC_WIDTH-1:0] FULL_OCC = OCC_WIDTH'(FLIT_BUFFER_DEPTH);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
  } flit_t;

  flit_t                mem_q [FLIT_BUFFER_DEPTH];
  flit_t                head;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_WIDTH-1:0] occ_q, occ_d;
  logic                 credit_q, credit_d;
  logic                 ovf_q, ovf_d;
  logic                 empty, full, push, pop;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign empty = (occ_q == '0);
  assign full  = (occ_q == FULL_OCC);
  assign pop   = !empty && axis_out_tready;
  // A full buffer still accepts a flit when the head leaves in the same cycle.
  assign push  = send_in && (!full || pop);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    credit_d = pop;
    ovf_d    = ovf_q | (send_in && full && !pop);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
      2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: flit storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_noc) begin
    if (push) mem_q[wr_ptr_q] <= '{data: data_in, dest: dest_in, tail: is_tail_in};
  end

  assign head            = mem_q[rd_ptr_q];
  assign axis_out_tvalid = !empty;
  assign axis_out_tdata  = head.data;
  assign axis_out_tlast  = head.tail;
  assign axis_out_tid    = head.dest[DEST_WIDTH-1 -: TID_WIDTH];
  assign axis_out_tdest  = head.dest[TDEST_WIDTH-1:0];
  assign credit_out      = credit_q;
  assign occupancy       = occ_q;
  assign overflow_err    = ovf_q;

endmodule

// File: tb/tb_noc_flit_credit_rx.sv
// Bench for noc_flit_credit_rx: directed flit vectors feed a scoreboard queue;
// a negedge monitor compares flits, credits, occupancy and error flag against a small model.
module tb_noc_flit_credit_rx;

  localparam int DEPTH = 8;

  logic        clk_noc = 1'b0;
  logic        rst_n;
  logic [63:0] data_in;
  logic [5:0]  dest_in;
  logic        is_tail_in;
  logic        send_in;
  logic        credit_out;
  logic        axis_out_tvalid;
  logic        axis_out_tready;
  logic [63:0] axis_out_tdata;
  logic        axis_out_tlast;
  logic [1:0]  axis_out_tid;
  logic [3:0]  axis_out_tdest;
  logic [3:0]  occupancy;
  logic        overflow_err;

  noc_flit_credit_rx dut (
    .clk_noc         (clk_noc),
    .rst_n           (rst_n),
    .data_in         (data_in),
    .dest_in         (dest_in),
    .is_tail_in      (is_tail_in),
    .send_in         (send_in),
    .credit_out      (credit_out),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tid    (axis_out_tid),
    .axis_out_tdest  (axis_out_tdest),
    .occupancy       (occupancy),
    .overflow_err    (overflow_err)
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  tid;
    logic [3:0]  tdest;
    logic        last;
  } exp_flit_t;

  exp_flit_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: reference model of occupancy/credit/error, updated once per cycle.
  int   m_occ    = 0;
  logic m_credit = 1'b0;
  logic m_ovf    = 1'b0;

  always @(negedge clk_noc) begin
    logic m_pop, m_push;
    exp_flit_t e;
    if (!rst_n) begin
      check("rst_credit", credit_out, 0);
      check("rst_tvalid", axis_out_tvalid, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_overflow", overflow_err, 0);
      sb_q.delete();
      m_occ = 0; m_credit = 1'b0; m_ovf = 1'b0;
    end else begin
      m_pop = (m_occ != 0) && axis_out_tready;
      check("credit", credit_out, m_credit);
      check("occupancy", occupancy, 64'(m_occ));
      check("tvalid", axis_out_tvalid, m_occ != 0);
      check("overflow", overflow_err, m_ovf);
      if (m_pop) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_flit at %0t: got data %0h expected none", $time, axis_out_tdata);
        end else begin
          e = sb_q.pop_front();
          check("tdata", axis_out_tdata, e.data);
          check("tid", axis_out_tid, e.tid);
          check("tdest", axis_out_tdest, e.tdest);
          check("tlast", axis_out_tlast, e.last);
        end
      end
      m_push = send_in && (m_occ < DEPTH || m_pop);
      if (send_in && m_occ == DEPTH && !m_pop) m_ovf = 1'b1;
      m_occ    = m_occ + int'(m_push) - int'(m_pop);
      m_credit = m_pop;
    end
  end

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic send_flit(input logic [63:0] d, input logic [1:0] tid, input logic [3:0] tdest,
                           input logic tail, input bit accept);
    exp_flit_t e;
    data_in = d; dest_in = {tid, tdest}; is_tail_in = tail; send_in = 1'b1;
    if (accept) begin
      e = '{data: d, tid: tid, tdest: tdest, last: tail};
      sb_q.push_back(e);
    end
    tick();
    send_in = 1'b0;
  endtask

  task automatic fill(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] td;
      td = 4'(i);
      send_flit(base + 64'(i), td[1:0], ~td, i == n - 1, 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0; send_in = 1'b0; data_in = '0; dest_in = '0;
    is_tail_in = 1'b0; axis_out_tready = 1'b0;
    #2;
    check("init_credit", credit_out, 0);
    check("init_tvalid", axis_out_tvalid, 0);
    check("init_occupancy", occupancy, 0);
    check("init_overflow", overflow_err, 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Idle with tready held: no credit may appear.
    axis_out_tready = 1'b1;
    repeat (20) tick();

    // Single flit: visible next cycle, credit one cycle after the pop.
    send_flit(64'hDEAD_BEEF_0000_0001, 2'b10, 4'b0110, 1'b1, 1'b1);
    check("single_tvalid", axis_out_tvalid, 1);
    check("single_tid", axis_out_tid, 2'b10);
    check("single_tdest", axis_out_tdest, 4'b0110);
    check("single_tlast", axis_out_tlast, 1);
    check("single_no_early_credit", credit_out, 0);
    tick();
    check("single_credit", credit_out, 1);
    tick();
    check("single_credit_once", credit_out, 0);
    repeat (2) tick();

    // Eight back-to-back flits with downstream stalled, then drain.
    axis_out_tready = 1'b0;
    fill(64'h0, DEPTH);
    tick();
    check("fill8_occupancy", occupancy, 8);
    check("fill8_no_credit", credit_out, 0);
    axis_out_tready = 1'b1;
    repeat (10) tick();
    check("drain8_occupancy", occupancy, 0);

    // Full buffer: push and pop in the same cycle is legal.
    axis_out_tready = 1'b0;
    fill(64'h10, DEPTH);
    axis_out_tready = 1'b1;
    send_flit(64'h18, 2'b01, 4'b1010, 1'b1, 1'b1);
    axis_out_tready = 1'b0;
    check("full_pushpop_occupancy", occupancy, 8);
    check("full_pushpop_no_error", overflow_err, 0);
    tick();
    axis_out_tready = 1'b1;
    repeat (10) tick();

    // Full buffer, no pop: flit dropped and error latched.
    axis_out_tready = 1'b0;
    fill(64'h20, DEPTH);
    send_flit(64'hFF, 2'b11, 4'b1111, 1'b1, 1'b0);
    check("overflow_set", overflow_err, 1);
    check("overflow_occupancy", occupancy, 8);
    tick();
    check("overflow_held", overflow_err, 1);
    axis_out_tready = 1'b1;
    repeat (10) tick();
    check("overflow_sticky", overflow_err, 1);
    check("overflow_drained", occupancy, 0);

    // Reset with a credit pulse in flight.
    axis_out_tready = 1'b0;
    fill(64'h30, 5);
    axis_out_tready = 1'b1;
    tick();
    check("pre_reset_credit", credit_out, 1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_credit_cancel", credit_out, 0);
    check("reset_tvalid", axis_out_tvalid, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_overflow", overflow_err, 0);
    axis_out_tready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    axis_out_tready = 1'b1;
    send_flit(64'hCAFE_F00D_0000_0042, 2'b01, 4'b0011, 1'b0, 1'b1);
    check("post_reset_tvalid", axis_out_tvalid, 1);
    tick();
    check("post_reset_credit", credit_out, 1);
    repeat (4) tick();

    check("scoreboard_drained", 64'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_flit_credit_rx.md
Name: noc_flit_credit_rx

Overview:
- Receive end of the credit-based router-to-router flit link. It terminates one router output port: `data`/`dest`/`is_tail`/`send` in, `credit` back.
- Flits go into a local FIFO of `FLIT_BUFFER_DEPTH` entries and are presented as an AXI-Stream master (`tid`/`tdest` split from `dest`).
- One credit pulse is returned for every flit consumed downstream.
- Used as a single-clock NoC-side sink for endpoint ports and for link-level verification of the router's credit accounting.

Parameters:
- TID_WIDTH, 2, width of the tid field carried in the upper bits of dest
- TDEST_WIDTH, 4, width of the tdest field carried in the lower bits of dest
- DEST_WIDTH, TDEST_WIDTH+TID_WIDTH, link dest field width
- FLIT_WIDTH, 64, link data width (equals tdata width; no deserialization)
- FLIT_BUFFER_DEPTH, 8, FIFO entries; equals the credits the sender holds after reset; must be ≥2
- OCC_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), occupancy counter width

Ports:
- clk_noc  in  1  NoC clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  FLIT_WIDTH  flit payload
- dest_in  in  DEST_WIDTH  {tid, tdest} of the flit
- is_tail_in  in  1  flit is last of packet
- send_in  in  1  flit valid this cycle (sender has spent one credit)
- credit_out  out  1  one-cycle pulse = one buffer slot freed
- axis_out_tvalid  out  1  head flit valid
- axis_out_tready  in  1  downstream accept
- axis_out_tdata  out  FLIT_WIDTH  head flit data
- axis_out_tlast  out  1  head flit is_tail
- axis_out_tid  out  TID_WIDTH  dest[DEST_WIDTH-1 -: TID_WIDTH] of head flit
- axis_out_tdest  out  TDEST_WIDTH  dest[TDEST_WIDTH-1:0] of head flit
- occupancy  out  OCC_WIDTH  flits currently stored
- overflow_err  out  1  sticky: flit arrived with the FIFO full and no pop

Behaviour:
- Reset (async assert, sync release):
  - `credit_out`=0, `axis_out_tvalid`=0, `occupancy`=0, `overflow_err`=0.
  - Read/write pointers are 0. Data/tdest/tid/tlast outputs are don't-care while tvalid=0.
  - No credits are issued at reset; the sender starts with `FLIT_BUFFER_DEPTH` credits.
- Push:
  - Occurs when `send_in`=1 and (occupancy<DEPTH, or a pop happens the same cycle).
  - The flit is stored at the write pointer; the pointer wraps DEPTH-1→0.
- Pop:
  - Occurs when `axis_out_tvalid` && `axis_out_tready`; the read pointer advances and wraps.
- Latency:
  - A flit pushed in cycle N drives `axis_out_tvalid`=1 with its fields from cycle N+1. This is first-word-fall-through from registered storage; there is no combinational path from `send_in` to the outputs.
- AXIS rules:
  - Output fields stay stable while tvalid=1 and tready=0.
  - tvalid is never withdrawn without a pop.
  - `tready` has no effect when tvalid=0.
- Credit return:
  - A pop in cycle N gives `credit_out`=1 in cycle N+1 only (registered).
  - Back-to-back pops give consecutive credit pulses, exactly one per pop, never merged.
- Occupancy:
  - Pushes add 1, pops subtract 1; a simultaneous push and pop leaves it unchanged.
  - Range 0..DEPTH. It never wraps.
- Full:
  - `send_in` with occupancy=DEPTH and a same-cycle pop is a legal push: no error, occupancy stays DEPTH.
  - `send_in` with occupancy=DEPTH and no pop drops the flit. `overflow_err` is set and held until reset; FIFO contents and pointers are unchanged.
- Empty:
  - With occupancy=0, a flit arriving on `send_in` is not visible until N+1. There is no same-cycle bypass.
- Packets:
  - `is_tail` is carried through as `tlast` unmodified.
  - Packet boundaries have no effect on buffering or credits. Interleaving is not checked.
- Reset mid-operation:
  - All stored flits are discarded and any pending credit pulse is cancelled (`credit_out`=0 immediately on `rst_n` low).
  - The sender is reset on the same `rst_n` and its credit count returns to DEPTH.

Test Plan:
- Reset → `credit_out`=0, `tvalid`=0, `occupancy`=0, `overflow_err`=0. Hold `tready`=1 with no send → no credit pulses for 20 cycles.
- Single flit (`data`=64'hDEAD_BEEF_0000_0001, `dest`=6'b10_0110, `tail`=1) at cycle 5, `tready`=1 → cycle 6: `tvalid`=1, `tid`=2'b10, `tdest`=4'b0110, `tlast`=1. Cycle 7: `credit_out`=1 for exactly one cycle.
- 8 back-to-back flits (data 0..7) with `tready`=0 → `occupancy`=8, no credits. Then `tready`=1 → data 0..7 out in order on 8 consecutive cycles, with 8 consecutive `credit_out` pulses each lagging its pop by 1 cycle. Ends with `occupancy`=0.
- FIFO full (8), `tready`=1 and `send_in`=1 in the same cycle → no error, `occupancy` stays 8, output order preserved across the pointer wrap.
- FIFO full, `tready`=0, `send_in`=1 with data 0xFF → `overflow_err`=1 from the next cycle and held. The dropped flit never appears; the 8 stored flits drain intact.
- 5 flits buffered, assert `rst_n`=0 for 1 cycle while a pop is in flight → `tvalid`, `credit_out` and `occupancy` all 0 during reset. After release, a new flit streams normally.
